// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 16-entry byte FIFO with a launch sequencer for a UART transmitter.
// Each stored byte is held on tx_data for its whole frame; start_trigger pulses once per byte.
module uart_tx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              start_trigger,
  output logic [DATA_W-1:0] tx_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);
  // Full is judged on the current count, so a pop in the same cycle never frees room for a push.
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty && !tx_busy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      start_trigger <= 1'b0;
      tx_data       <= '0;
      state         <= IDLE;
    end else begin
      overflow <= wr_en && full;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // tx_data is only ever loaded on the IDLE->START edge; the transmitter reads it live.
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data       <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1'b1;
            start_trigger <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          start_trigger <= 1'b0;
          state         <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            state <= IDLE;
          end
        end
        default: begin
          start_trigger <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
